// File: rtl/eco32_core_idu_rfu_wba.sv
// Register-file writeback arbiter: merges execute (A) and load-return (B) writes
// onto one byte-enabled write port, and zeroes all 32 registers after reset or clear.
module eco32_core_idu_rfu_wba (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic [3:0]  a_ben,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [3:0]  b_ben,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ack,
  input  logic        i_clr,
  output logic        w_ena,
  output logic [3:0]  w_ben,
  output logic [4:0]  w_addr,
  output logic [31:0] w_data,
  output logic        o_busy
);

  typedef enum logic {INIT, RUN} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [1:0]  starv, starv_nxt;
  logic        w_ena_nxt, busy_nxt;
  logic [3:0]  w_ben_nxt, g_ben;
  logic [4:0]  w_addr_nxt, g_addr;
  logic [31:0] w_data_nxt, g_data;
  logic        grant_a, grant_b;

  // B wins over A only once it has been refused three RUN cycles in a row.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == RUN && !i_clr) begin
      if (b_req && (!a_req || starv == 2'd3)) grant_b = 1'b1;
      else if (a_req)                        grant_a = 1'b1;
    end
  end

  assign a_ack  = grant_a;
  assign b_ack  = grant_b;
  assign g_ben  = grant_b ? b_ben  : a_ben;
  assign g_addr = grant_b ? b_addr : a_addr;
  assign g_data = grant_b ? b_data : a_data;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    starv_nxt  = starv;
    busy_nxt   = o_busy;
    w_ena_nxt  = 1'b0;
    w_ben_nxt  = w_ben;
    w_addr_nxt = w_addr;
    w_data_nxt = w_data;
    case (state)
      INIT: begin
        w_ena_nxt  = 1'b1;
        w_ben_nxt  = 4'hF;
        w_addr_nxt = cnt;
        w_data_nxt = '0;
        starv_nxt  = '0;
        if (i_clr) begin
          cnt_nxt = '0;
        end else if (cnt == 5'd31) begin
          state_nxt = RUN;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      RUN: begin
        if (i_clr) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          starv_nxt = '0;
        end else begin
          if (grant_a || grant_b) begin
            // Writes to r0 or with no enabled bytes are acked but suppressed.
            w_ena_nxt  = (g_addr != 5'd0) && (g_ben != 4'd0);
            w_ben_nxt  = g_ben;
            w_addr_nxt = g_addr;
            w_data_nxt = g_data;
          end
          if (grant_b || !b_req)   starv_nxt = '0;
          else if (starv != 2'd3)  starv_nxt = starv + 2'd1;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= INIT;
      cnt    <= '0;
      starv  <= '0;
      o_busy <= 1'b1;
      w_ena  <= 1'b0;
      w_ben  <= '0;
      w_addr <= '0;
      w_data <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      starv  <= starv_nxt;
      o_busy <= busy_nxt;
      w_ena  <= w_ena_nxt;
      w_ben  <= w_ben_nxt;
      w_addr <= w_addr_nxt;
      w_data <= w_data_nxt;
    end
  end

endmodule

// File: tb/tb_eco32_core_idu_rfu_wba.sv
// Randomized scoreboard bench for the writeback arbiter: a behavioural model
// predicts acks and register-file writes; separate monitors compare them.
module tb_eco32_core_idu_rfu_wba;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req, i_clr;
  logic [3:0]  a_ben, b_ben;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ack, b_ack;
  logic        w_ena, o_busy;
  logic [3:0]  w_ben;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  eco32_core_idu_rfu_wba dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_ben(a_ben), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_ben(b_ben), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .i_clr(i_clr),
    .w_ena(w_ena), .w_ben(w_ben), .w_addr(w_addr), .w_data(w_data), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic a_ack;
    logic b_ack;
  } ack_t;

  typedef struct {
    logic        ena;
    logic [3:0]  ben;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        busy;
  } wr_t;

  ack_t ackq[$];
  wr_t  wrq[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, in terms of the observable behaviour.
  bit          m_busy;
  int          m_clr_idx;
  int          m_b_wait;   // consecutive RUN cycles B has been refused
  logic [3:0]  m_ben;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  // Requester agents
  bit          pa, pb;
  logic [3:0]  ra_ben, rb_ben;
  logic [4:0]  ra_addr, rb_addr;
  logic [31:0] ra_data, rb_data;

  task automatic model_reset();
    m_busy = 1; m_clr_idx = 0; m_b_wait = 0;
    m_ben = '0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_step(input bit ar, input bit br, input bit clr);
    ack_t a;
    wr_t  w;
    bit   ga, gb;
    ga = 0; gb = 0;
    w.ena = 0;
    if (m_busy) begin
      w.ena = 1; m_ben = 4'hF; m_addr = 5'(m_clr_idx); m_data = 0;
      m_b_wait = 0;
      if (clr)                  m_clr_idx = 0;
      else if (m_clr_idx == 31) begin m_busy = 0; m_clr_idx = 0; end
      else                      m_clr_idx++;
    end else if (clr) begin
      m_busy = 1; m_clr_idx = 0; m_b_wait = 0;
    end else begin
      if (br && (!ar || m_b_wait >= 3)) gb = 1;
      else if (ar)                      ga = 1;
      if (ga) begin m_ben = ra_ben; m_addr = ra_addr; m_data = ra_data; end
      if (gb) begin m_ben = rb_ben; m_addr = rb_addr; m_data = rb_data; end
      if (ga || gb) w.ena = (m_addr != 0) && (m_ben != 0);
      m_b_wait = (br && !gb) ? m_b_wait + 1 : 0;
    end
    a.a_ack = ga; a.b_ack = gb;
    w.ben = m_ben; w.addr = m_addr; w.data = m_data; w.busy = m_busy;
    ackq.push_back(a);
    wrq.push_back(w);
    if (ga) pa = 0;
    if (gb) pb = 0;
  endtask

  // Acks are combinational: sample mid-cycle, well after inputs settle.
  initial forever begin
    ack_t e;
    @(negedge clk);
    if (ackq.size() > 0) begin
      e = ackq.pop_front();
      check("a_ack", 32'(a_ack), 32'(e.a_ack));
      check("b_ack", 32'(b_ack), 32'(e.b_ack));
    end
  end

  initial forever begin
    wr_t e;
    @(posedge clk);
    #1;
    if (wrq.size() > 0) begin
      e = wrq.pop_front();
      check("w_ena", 32'(w_ena), 32'(e.ena));
      check("o_busy", 32'(o_busy), 32'(e.busy));
      if (e.ena) begin
        check("w_ben", 32'(w_ben), 32'(e.ben));
        check("w_addr", 32'(w_addr), 32'(e.addr));
        check("w_data", w_data, e.data);
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_w_ena", 32'(w_ena), 32'd0);
    check("rst_w_ben", 32'(w_ben), 32'd0);
    check("rst_w_addr", 32'(w_addr), 32'd0);
    check("rst_w_data", w_data, 32'd0);
    check("rst_o_busy", 32'(o_busy), 32'd1);
    check("rst_a_ack", 32'(a_ack), 32'd0);
    check("rst_b_ack", 32'(b_ack), 32'd0);
  endtask

  // One cycle of stimulus: called #2 after a rising edge.
  task automatic drive_cycle(input int pa_pct, input int pb_pct, input int clr_pct);
    bit clr;
    if (!pa && ($urandom % 100) < pa_pct) begin
      pa = 1; ra_addr = 5'($urandom); ra_ben = 4'($urandom); ra_data = $urandom;
      if (($urandom % 8) == 0) ra_ben = 4'hF;
    end
    if (!pb && ($urandom % 100) < pb_pct) begin
      pb = 1; rb_addr = 5'($urandom); rb_ben = 4'($urandom); rb_data = $urandom;
      if (($urandom % 8) == 0) rb_addr = 5'd0;
    end
    clr = !m_busy && (($urandom % 1000) < clr_pct);
    a_req = pa; a_ben = ra_ben; a_addr = ra_addr; a_data = ra_data;
    b_req = pb; b_ben = rb_ben; b_addr = rb_addr; b_data = rb_data;
    i_clr = clr;
    model_step(pa, pb, clr);
  endtask

  initial begin
    rst_n = 0; i_clr = 0;
    pa = 1; pb = 0;
    ra_addr = 5'd5; ra_ben = 4'h3; ra_data = 32'h1234_5678;
    rb_addr = '0; rb_ben = '0; rb_data = '0;
    a_req = 1; a_ben = ra_ben; a_addr = ra_addr; a_data = ra_data;
    b_req = 0; b_ben = '0; b_addr = '0; b_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs();

    // Release with A already requesting: 32 zeroing writes, then A granted.
    rst_n = 1;
    for (int i = 0; i < 34; i++) begin
      drive_cycle(0, 0, 0);
      @(posedge clk); #2;
    end

    // Both requesters saturated: exercises the A,A,A,B pattern.
    for (int i = 0; i < 40; i++) begin
      drive_cycle(100, 100, 0);
      @(posedge clk); #2;
    end

    // Mixed random traffic with occasional clears.
    for (int i = 0; i < 600; i++) begin
      drive_cycle(60, 50, 15);
      @(posedge clk); #2;
    end

    // Force a clear, then reset in the middle of INIT at count 10.
    drive_cycle(100, 0, 1000);
    @(posedge clk); #2;
    for (int i = 0; i < 200 && !(m_busy && m_clr_idx == 10); i++) begin
      drive_cycle(50, 50, 0);
      @(posedge clk); #2;
    end
    check("init_cnt10_reached", 32'(m_busy && m_clr_idx == 10), 32'd1);
    a_req = 1;
    rst_n = 0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs();
    rst_n = 1;
    for (int i = 0; i < 200; i++) begin
      drive_cycle(60, 60, 5);
      @(posedge clk); #2;
    end

    @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
